// File: rtl/lsu_ctrl_pkg.sv
// Shared load/store encodings and LSU FSM states.
// Used by the CPU pipeline, the LSU and the data memory.
package lsu_ctrl_pkg;

    localparam int RD_EN_BIT = 3;
    localparam int WR_EN_BIT = 2;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic [3:0] DMEM_RD_NONE = 4'b0000;
    localparam logic [2:0] DMEM_WR_NONE = 3'b000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE,
        ST_ERR
    } lsu_state_e;

    // Loads and stores share the size field in bits [1:0].
    function automatic logic misaligned(input logic [1:0] size,
                                        input logic [1:0] lsb);
        logic m;
        m = 1'b0;
        unique case (size)
            SZ_BYTE: m = 1'b0;
            SZ_HALF: m = lsb[0];
            default: m = (lsb != 2'b00);
        endcase
        return m;
    endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// Data-memory bus between the LSU (master) and dmem (slave).
// Request: DMEM_READ/DMEM_WRITE codes, address, store data; response: data, BUSYWAIT.
interface lsu_ctrl_if;
    logic [3:0]  DMEM_READ;
    logic [2:0]  DMEM_WRITE;
    logic [31:0] DMEM_ADDR;
    logic [31:0] DMEM_DATA_WRITE;
    logic [31:0] DMEM_DATA_READ;
    logic        BUSYWAIT;

    modport master (
        output DMEM_READ,
        output DMEM_WRITE,
        output DMEM_ADDR,
        output DMEM_DATA_WRITE,
        input  DMEM_DATA_READ,
        input  BUSYWAIT
    );

    modport slave (
        input  DMEM_READ,
        input  DMEM_WRITE,
        input  DMEM_ADDR,
        input  DMEM_DATA_WRITE,
        output DMEM_DATA_READ,
        output BUSYWAIT
    );
endinterface

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: issues one data-memory access per request,
// waits on BUSYWAIT with a timeout, and reports load data or an exception.
// Ports: CLK, RST (sync, active-high); MEM_READ_IN/MEM_WRITE_IN/ADDR_IN/WDATA_IN
// from the MA stage; dmem (master bus); LSU_STALL, LOAD_DATA_OUT, LOAD_VALID,
// MISALIGN_OUT, BUS_ERR_OUT back to the pipeline.
module lsu_ctrl
    import lsu_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [3:0]        MEM_READ_IN,
    input  logic [2:0]        MEM_WRITE_IN,
    input  logic [31:0]       ADDR_IN,
    input  logic [31:0]       WDATA_IN,
    lsu_ctrl_if.master        dmem,
    output logic              LSU_STALL,
    output logic [31:0]       LOAD_DATA_OUT,
    output logic              LOAD_VALID,
    output logic              MISALIGN_OUT,
    output logic              BUS_ERR_OUT
);

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    lsu_state_e  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [3:0]  rd_q, rd_d;
    logic [2:0]  wr_q, wr_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] ldata_q, ldata_d;
    logic        lv_q, lv_d;
    logic        mis_q, mis_d;
    logic        be_q, be_d;

    logic        rd_req;
    logic        wr_req;
    logic        both_req;
    logic        mis_hit;
    logic [1:0]  req_size;

    assign rd_req   = MEM_READ_IN[RD_EN_BIT];
    assign wr_req   = MEM_WRITE_IN[WR_EN_BIT];
    assign both_req = rd_req && wr_req;
    assign req_size = rd_req ? MEM_READ_IN[1:0] : MEM_WRITE_IN[1:0];
    // Dual-enable is reported as a bus error, so it masks misalignment.
    assign mis_hit  = !both_req && misaligned(req_size, ADDR_IN[1:0]);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rd_q    <= DMEM_RD_NONE;
            wr_q    <= DMEM_WR_NONE;
            addr_q  <= '0;
            wdata_q <= '0;
            ldata_q <= '0;
            lv_q    <= 1'b0;
            mis_q   <= 1'b0;
            be_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ldata_q <= ldata_d;
            lv_q    <= lv_d;
            mis_q   <= mis_d;
            be_q    <= be_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        ldata_d = ldata_q;
        lv_d    = 1'b0;
        mis_d   = 1'b0;
        be_d    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (rd_req || wr_req) begin
                    unique case (1'b1)
                        both_req: begin
                            be_d    = 1'b1;
                            state_d = ST_ERR;
                        end
                        mis_hit: begin
                            mis_d   = 1'b1;
                            state_d = ST_ERR;
                        end
                        default: begin
                            rd_d    = MEM_READ_IN;
                            wr_d    = MEM_WRITE_IN;
                            addr_d  = ADDR_IN;
                            wdata_d = WDATA_IN;
                            cnt_d   = '0;
                            state_d = ST_ISSUE;
                        end
                    endcase
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (!dmem.BUSYWAIT) begin
                    if (rd_q[RD_EN_BIT]) begin
                        ldata_d = dmem.DMEM_DATA_READ;
                        lv_d    = 1'b1;
                    end
                    rd_d    = DMEM_RD_NONE;
                    wr_d    = DMEM_WR_NONE;
                    state_d = ST_DONE;
                end else if (cnt_q == TO_LAST) begin
                    // This busy cycle is the TIMEOUT_CYCLES-th one.
                    rd_d    = DMEM_RD_NONE;
                    wr_d    = DMEM_WR_NONE;
                    be_d    = 1'b1;
                    state_d = ST_ERR;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        LSU_STALL = 1'b0;
        unique case (state_q)
            ST_IDLE:  LSU_STALL = rd_req || wr_req;
            ST_ISSUE: LSU_STALL = 1'b1;
            ST_WAIT:  LSU_STALL = 1'b1;
            default:  LSU_STALL = 1'b0;
        endcase
    end

    assign dmem.DMEM_READ       = rd_q;
    assign dmem.DMEM_WRITE      = wr_q;
    assign dmem.DMEM_ADDR       = addr_q;
    assign dmem.DMEM_DATA_WRITE = wdata_q;
    assign LOAD_DATA_OUT        = ldata_q;
    assign LOAD_VALID           = lv_q;
    assign MISALIGN_OUT         = mis_q;
    assign BUS_ERR_OUT          = be_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Testbench for lsu_ctrl: directed scenarios plus randomized accesses
// compared cycle by cycle against a transaction-level timeline model.
module tb_lsu_ctrl;

    localparam int TO   = 4;
    localparam int MAXC = 16;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [3:0]  MEM_READ_IN = '0;
    logic [2:0]  MEM_WRITE_IN = '0;
    logic [31:0] ADDR_IN = '0;
    logic [31:0] WDATA_IN = '0;
    logic        LSU_STALL;
    logic [31:0] LOAD_DATA_OUT;
    logic        LOAD_VALID;
    logic        MISALIGN_OUT;
    logic        BUS_ERR_OUT;

    lsu_ctrl_if dmem_if ();

    always #5 CLK = ~CLK;

    lsu_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .MEM_READ_IN  (MEM_READ_IN),
        .MEM_WRITE_IN (MEM_WRITE_IN),
        .ADDR_IN      (ADDR_IN),
        .WDATA_IN     (WDATA_IN),
        .dmem         (dmem_if),
        .LSU_STALL    (LSU_STALL),
        .LOAD_DATA_OUT(LOAD_DATA_OUT),
        .LOAD_VALID   (LOAD_VALID),
        .MISALIGN_OUT (MISALIGN_OUT),
        .BUS_ERR_OUT  (BUS_ERR_OUT)
    );

    typedef struct packed {
        logic       stall;
        logic [3:0] rd;
        logic [2:0] wr;
        logic       lv;
        logic       mis;
        logic       be;
    } snap_t;

    snap_t       obs   [MAXC];
    snap_t       exp_t [MAXC];
    logic [31:0] obs_addr [MAXC];
    logic [31:0] obs_wd   [MAXC];
    logic [31:0] obs_ld   [MAXC];
    int          exp_end;
    bit          exp_legal;
    bit          exp_load_ok;
    int          n_chk = 0;
    int          n_pass = 0;

    // Timeline of one access. Cycle 0 is the cycle the request is seen
    // in IDLE; exp_end is the cycle of the DONE/ERR report.
    function automatic void model(input logic [3:0] rd, input logic [2:0] wr,
                                  input logic [31:0] addr, input int busy_n,
                                  input int len);
        bit ld, st, tmo;
        int bytes;
        ld = rd[3];
        st = wr[2];
        tmo = 1'b0;
        exp_legal = 1'b0;
        bytes = 1 << (ld ? int'(rd[1:0]) : int'(wr[1:0]));
        if (ld && st) begin
            exp_end = 1;
        end else if ((int'(addr[2:0]) % bytes) != 0) begin
            exp_end = 1;
        end else begin
            exp_legal = 1'b1;
            if (busy_n >= TO) begin
                tmo = 1'b1;
                exp_end = 2 + TO;
            end else begin
                exp_end = 3 + busy_n;
            end
        end
        exp_load_ok = exp_legal && !tmo && ld;
        for (int c = 0; c < len; c++) begin
            exp_t[c] = '0;
            exp_t[c].stall = (c < exp_end);
            if (exp_legal && c >= 1 && c < exp_end) begin
                exp_t[c].rd = rd;
                exp_t[c].wr = wr;
            end
            exp_t[c].lv  = (c == exp_end) && exp_load_ok;
            exp_t[c].mis = (c == exp_end) && !exp_legal && !(ld && st);
            exp_t[c].be  = (c == exp_end) && ((ld && st) || tmo);
        end
    endfunction

    // Drives one request for len cycles and records what the DUT shows.
    task automatic drive(input logic [3:0] rd, input logic [2:0] wr,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdata, input int busy_n,
                         input int hold, input int rst_cyc, input int len);
        bit bw;
        for (int c = 0; c < len; c++) begin
            @(negedge CLK);
            MEM_READ_IN  = (c <= hold) ? rd : 4'b0;
            MEM_WRITE_IN = (c <= hold) ? wr : 3'b0;
            ADDR_IN      = addr;
            WDATA_IN     = wdata;
            bw = (c == 1) || (c >= 2 && c < 2 + busy_n);
            dmem_if.BUSYWAIT       = bw;
            dmem_if.DMEM_DATA_READ = bw ? $urandom : rdata;
            RST = (c == rst_cyc);
            #1;
            obs[c] = {LSU_STALL, dmem_if.DMEM_READ, dmem_if.DMEM_WRITE,
                      LOAD_VALID, MISALIGN_OUT, BUS_ERR_OUT};
            obs_addr[c] = dmem_if.DMEM_ADDR;
            obs_wd[c]   = dmem_if.DMEM_DATA_WRITE;
            obs_ld[c]   = LOAD_DATA_OUT;
        end
        MEM_READ_IN  = '0;
        MEM_WRITE_IN = '0;
        RST          = 1'b0;
        dmem_if.BUSYWAIT = 1'b0;
    endtask

    task automatic test_reset;
        RST = 1'b1;
        dmem_if.BUSYWAIT = 1'b0;
        dmem_if.DMEM_DATA_READ = '0;
        repeat (2) @(negedge CLK);
        #1;
        n_chk++;
        if (LSU_STALL !== 1'b0) $display("FAIL rst_stall got %b want 0", LSU_STALL);
        else n_pass++;
        n_chk++;
        if (dmem_if.DMEM_READ !== 4'b0) $display("FAIL rst_rd got %h want 0", dmem_if.DMEM_READ);
        else n_pass++;
        n_chk++;
        if (dmem_if.DMEM_WRITE !== 3'b0) $display("FAIL rst_wr got %h want 0", dmem_if.DMEM_WRITE);
        else n_pass++;
        n_chk++;
        if (dmem_if.DMEM_ADDR !== 32'b0) $display("FAIL rst_addr got %h want 0", dmem_if.DMEM_ADDR);
        else n_pass++;
        n_chk++;
        if (dmem_if.DMEM_DATA_WRITE !== 32'b0) $display("FAIL rst_wd got %h want 0", dmem_if.DMEM_DATA_WRITE);
        else n_pass++;
        n_chk++;
        if (LOAD_DATA_OUT !== 32'b0) $display("FAIL rst_ld got %h want 0", LOAD_DATA_OUT);
        else n_pass++;
        n_chk++;
        if ({LOAD_VALID, MISALIGN_OUT, BUS_ERR_OUT} !== 3'b0)
            $display("FAIL rst_pulses got %b want 000", {LOAD_VALID, MISALIGN_OUT, BUS_ERR_OUT});
        else n_pass++;
        @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic test_load_busy;
        int len, nst;
        model(4'b1010, 3'b000, 32'h10, 2, MAXC);
        len = exp_end + 2;
        drive(4'b1010, 3'b000, 32'h10, 32'h0, 32'hDEADBEEF, 2, exp_end, -1, len);
        nst = 0;
        for (int c = 0; c < len; c++) begin
            nst += int'(obs[c].stall);
            n_chk++;
            if (obs[c] !== exp_t[c]) $display("FAIL lw_busy cyc%0d got %h want %h", c, obs[c], exp_t[c]);
            else n_pass++;
        end
        n_chk++;
        if (nst !== 5) $display("FAIL lw_busy_stall got %0d want 5", nst);
        else n_pass++;
        n_chk++;
        if (obs_addr[1] !== 32'h10) $display("FAIL lw_busy_addr got %h want 00000010", obs_addr[1]);
        else n_pass++;
        n_chk++;
        if (obs_ld[exp_end] !== 32'hDEADBEEF) $display("FAIL lw_busy_data got %h want deadbeef", obs_ld[exp_end]);
        else n_pass++;
    endtask

    task automatic test_misalign;
        int len, nst;
        model(4'b0000, 3'b101, 32'h3, 0, MAXC);
        len = exp_end + 2;
        drive(4'b0000, 3'b101, 32'h3, 32'hA5A5A5A5, 32'h0, 0, exp_end, -1, len);
        nst = 0;
        for (int c = 0; c < len; c++) begin
            nst += int'(obs[c].stall);
            n_chk++;
            if (obs[c] !== exp_t[c]) $display("FAIL sh_mis cyc%0d got %h want %h", c, obs[c], exp_t[c]);
            else n_pass++;
        end
        n_chk++;
        if (nst !== 1) $display("FAIL sh_mis_stall got %0d want 1", nst);
        else n_pass++;
    endtask

    task automatic test_timeout;
        int len;
        model(4'b0000, 3'b110, 32'h20, 20, MAXC);
        len = exp_end + 2;
        drive(4'b0000, 3'b110, 32'h20, 32'h12345678, 32'h0, 20, exp_end, -1, len);
        for (int c = 0; c < len; c++) begin
            n_chk++;
            if (obs[c] !== exp_t[c]) $display("FAIL sw_tmo cyc%0d got %h want %h", c, obs[c], exp_t[c]);
            else n_pass++;
        end
        n_chk++;
        if (obs_wd[1] !== 32'h12345678) $display("FAIL sw_tmo_wd got %h want 12345678", obs_wd[1]);
        else n_pass++;
    endtask

    task automatic test_both;
        int len;
        model(4'b1010, 3'b110, 32'h40, 0, MAXC);
        len = exp_end + 2;
        drive(4'b1010, 3'b110, 32'h40, 32'h0, 32'h0, 0, exp_end, -1, len);
        for (int c = 0; c < len; c++) begin
            n_chk++;
            if (obs[c] !== exp_t[c]) $display("FAIL both cyc%0d got %h want %h", c, obs[c], exp_t[c]);
            else n_pass++;
        end
    endtask

    task automatic test_lbu_min;
        int len, first;
        model(4'b1100, 3'b000, 32'h1, 0, MAXC);
        len = exp_end + 2;
        drive(4'b1100, 3'b000, 32'h1, 32'h0, 32'h000000C3, 0, exp_end, -1, len);
        first = -1;
        for (int c = 0; c < len; c++) begin
            if (first < 0 && obs[c].lv) first = c;
            n_chk++;
            if (obs[c] !== exp_t[c]) $display("FAIL lbu cyc%0d got %h want %h", c, obs[c], exp_t[c]);
            else n_pass++;
        end
        n_chk++;
        if (first !== 3) $display("FAIL lbu_latency got %0d want 3", first);
        else n_pass++;
        n_chk++;
        if (obs_ld[3] !== 32'h000000C3) $display("FAIL lbu_data got %h want 000000c3", obs_ld[3]);
        else n_pass++;
    endtask

    task automatic test_reset_abort;
        logic [31:0] a;
        a = $urandom & 32'hFFFF_FFFC;
        model(4'b1000, 3'b000, a, 20, MAXC);
        for (int c = 4; c < 7; c++) exp_t[c] = '0;
        drive(4'b1000, 3'b000, a, 32'h0, 32'h0, 20, 3, 3, 7);
        for (int c = 0; c < 7; c++) begin
            n_chk++;
            if (obs[c] !== exp_t[c]) $display("FAIL rst_abort cyc%0d got %h want %h", c, obs[c], exp_t[c]);
            else n_pass++;
        end
        n_chk++;
        if (obs_ld[4] !== 32'h0) $display("FAIL rst_abort_ld got %h want 0", obs_ld[4]);
        else n_pass++;
        n_chk++;
        if (obs_addr[4] !== 32'h0) $display("FAIL rst_abort_addr got %h want 0", obs_addr[4]);
        else n_pass++;
    endtask

    task automatic test_random;
        logic [2:0]  f3_tab [5];
        logic [3:0]  rd;
        logic [2:0]  wr;
        logic [31:0] a, wd, rdat;
        int          k, busy_n, len;
        f3_tab[0] = 3'b000;
        f3_tab[1] = 3'b001;
        f3_tab[2] = 3'b010;
        f3_tab[3] = 3'b100;
        f3_tab[4] = 3'b101;
        for (int i = 0; i < 40; i++) begin
            k = int'($urandom_range(0, 9));
            rd = '0;
            wr = '0;
            if (k == 0) begin
                rd = {1'b1, f3_tab[$urandom_range(0, 4)]};
                wr = {1'b1, 2'($urandom_range(0, 2))};
            end else if (k < 6) begin
                rd = {1'b1, f3_tab[$urandom_range(0, 4)]};
            end else begin
                wr = {1'b1, 2'($urandom_range(0, 2))};
            end
            a = $urandom;
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            wd = $urandom;
            rdat = $urandom;
            busy_n = int'($urandom_range(0, 5));
            model(rd, wr, a, busy_n, MAXC);
            len = exp_end + 2;
            drive(rd, wr, a, wd, rdat, busy_n, exp_end, -1, len);
            for (int c = 0; c < len; c++) begin
                n_chk++;
                if (obs[c] !== exp_t[c])
                    $display("FAIL rnd%0d cyc%0d got %h want %h", i, c, obs[c], exp_t[c]);
                else n_pass++;
            end
            if (exp_legal) begin
                n_chk++;
                if (obs_addr[1] !== a || obs_wd[1] !== wd)
                    $display("FAIL rnd%0d_bus got %h/%h want %h/%h", i, obs_addr[1], obs_wd[1], a, wd);
                else n_pass++;
            end
            if (exp_load_ok) begin
                n_chk++;
                if (obs_ld[exp_end] !== rdat)
                    $display("FAIL rnd%0d_data got %h want %h", i, obs_ld[exp_end], rdat);
                else n_pass++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_load_busy();
        test_misalign();
        test_timeout();
        test_both();
        test_lbu_min();
        test_reset_abort();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
